uart_receiver: RTL and testbench

Receive half of the UART block: oversamples an asynchronous serial line, recovers 8N1-style frames (start bit, DATA_SIZE data bits LSB first, one stop bit) and pushes each good word into an internal receive FIFO. The host pops words with a read strobe and monitors `status_register`. It pairs with the UART transmitter and shares its status-register layout philosophy and FIFO depth parameter.

---
 rtl/uart_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start/data/stop recovery into a first-word
// fall-through receive FIFO with sticky frame and overrun error flags.
module uart_receiver #(
    parameter int DATA_SIZE  = 8,
    parameter int SIZE_FIFO  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 serial_data_in,
    input  logic                 read_data,
    input  logic                 clear_error,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [7:0]           status_register
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_SIZE + 1);
    localparam int PW = $clog2(SIZE_FIFO);
    localparam int NW = $clog2(SIZE_FIFO + 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_SIZE - 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(SIZE_FIFO);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic                   push_s, pop_s, set_frame_s, set_ovr_s;
    logic [DATA_SIZE-1:0]   mem_q [SIZE_FIFO];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]          count_q, count_d;
    logic                   full_q, empty_q, frame_err_q, ovr_err_q;
    logic                   frame_err_d, ovr_err_d;
    logic [DATA_SIZE-1:0]   data_out_q, data_out_d;

    // Frame recovery FSM; armed_q blocks restarts until the line has been seen high after a break
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        push_s      = 1'b0;
        set_frame_s = 1'b0;
        set_ovr_s   = 1'b0;
        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        armed_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s_q) begin
                            cnt_d     = '0;
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_END) begin
                        shift_d   = {rx_s_q, shift_q[DATA_SIZE-1:1]};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        cnt_d     = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_END) begin
                        state_d = ST_IDLE;
                        if (!rx_s_q) begin
                            set_frame_s = 1'b1;
                            armed_d     = 1'b0;
                        end else if (!full_q || read_data) begin
                            push_s = 1'b1;
                        end else begin
                            set_ovr_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO pointers, occupancy, next head word and sticky error flags
    always_comb begin
        pop_s    = read_data && !empty_q;
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        // The head slot may be written this same cycle, so bypass the new word
        if (count_d == NW'(0)) begin
            data_out_d = '0;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            data_out_d = shift_q;
        end else begin
            data_out_d = mem_q[rd_ptr_d];
        end
        if (set_frame_s) begin
            frame_err_d = 1'b1;
        end else if (clear_error) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        if (set_ovr_s) begin
            ovr_err_d = 1'b1;
        end else if (clear_error) begin
            ovr_err_d = 1'b0;
        end else begin
            ovr_err_d = ovr_err_q;
        end
    end

    // Control and status state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
            data_out_q  <= '0;
        end else begin
            rx_meta_q   <= serial_data_in;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == FIFO_FULL);
            empty_q     <= (count_d == NW'(0));
            frame_err_q <= frame_err_d;
            ovr_err_q   <= ovr_err_d;
            data_out_q  <= data_out_d;
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign data_out        = data_out_q;
    assign status_register = {4'b0000, ovr_err_q, frame_err_q, full_q, empty_q};
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames with expected status/data,
// plus hand sequences for draining, push/pop at full and reset mid-frame.
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       serial_data_in = 1'b1;
    logic       read_data = 1'b0;
    logic       clear_error = 1'b0;
    logic [7:0] data_out;
    logic [7:0] status_register;
    int         checks = 0;
    int         failures = 0;
    int         div = 0;

    uart_receiver #(.DATA_SIZE(8), .SIZE_FIFO(8), .OVERSAMPLE(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .baud_tick       (baud_tick),
        .serial_data_in  (serial_data_in),
        .read_data       (read_data),
        .clear_error     (clear_error),
        .data_out        (data_out),
        .status_register (status_register)
    );

    always #5 clk = ~clk;

    // baud_tick every 4 clk
    initial begin
        forever begin
            @(negedge clk);
            div = (div == 3) ? 0 : div + 1;
            baud_tick = (div == 3);
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic [1:0] act;   // 0 none, 1 pop, 2 clear_error
        logic [7:0] st1;
        logic [7:0] do1;
        logic [7:0] st2;
        logic [7:0] do2;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Tick 0 is aligned to frame start; stop bit is sampled at tick 153 by construction
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pop_at_stop, input logic rst_mid);
        logic [9:0] bits;
        int n;
        bits = {stop, d, 1'b0};
        n = 0;
        step();
        while (baud_tick !== 1'b1) step();
        serial_data_in = 1'b0;
        while (n < 160) begin
            step();
            read_data = 1'b0;
            if (baud_tick) begin
                n++;
                if ((n % 16 == 0) && (n < 160)) serial_data_in = bits[n/16];
                if (pop_at_stop && n == 153) read_data = 1'b1;
                if (rst_mid && n == 88) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    n = 160;
                end
            end
        end
        serial_data_in = 1'b1;
    endtask

    task automatic pulse_read();
        read_data = 1'b1;
        step();
        read_data = 1'b0;
        step();
    endtask

    task automatic pulse_clear();
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 2'd1, 8'h00, 8'hA5, 8'h01, 8'h00};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 2'd1, 8'h00, 8'h3C, 8'h01, 8'h00};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 2'd2, 8'h05, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 2'd1, 8'h00, 8'h81, 8'h01, 8'h00};
        for (int i = 0; i < 7; i++)
            vecs[4+i] = '{8'(i), 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{8'h07, 1'b1, 1'b0, 2'd0, 8'h02, 8'h00, 8'h02, 8'h00};
        vecs[12] = '{8'h08, 1'b1, 1'b0, 2'd0, 8'h0A, 8'h00, 8'h0A, 8'h00};

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_status", status_register, 8'h01);
        chk("reset_data", data_out, 8'h00);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].glitch) begin
                serial_data_in = 1'b0;
                repeat (16) step();
                serial_data_in = 1'b1;
                repeat (200) step();
                chk("glitch_status", status_register, 8'h01);
            end
            send_frame(vecs[v].data, vecs[v].stop, 1'b0, 1'b0);
            chk($sformatf("vec%0d_status", v), status_register, vecs[v].st1);
            chk($sformatf("vec%0d_data", v), data_out, vecs[v].do1);
            if (vecs[v].act == 2'd1) pulse_read();
            else if (vecs[v].act == 2'd2) pulse_clear();
            else step();
            chk($sformatf("vec%0d_status_after", v), status_register, vecs[v].st2);
            chk($sformatf("vec%0d_data_after", v), data_out, vecs[v].do2);
        end

        // drain: 0x08 was dropped, overrun stays sticky
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), data_out, 8'(i));
            pulse_read();
        end
        chk("drained_status", status_register, 8'h09);
        chk("drained_data", data_out, 8'h00);
        pulse_clear();
        chk("cleared_status", status_register, 8'h01);

        // push and pop on the same stop tick while full
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
        chk("full_status", status_register, 8'h02);
        send_frame(8'h28, 1'b1, 1'b1, 1'b0);
        chk("pushpop_status", status_register, 8'h02);
        chk("pushpop_head", data_out, 8'h21);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), data_out, 8'h21 + 8'(i));
            pulse_read();
        end
        chk("pp_empty", status_register, 8'h01);

        // reset during bit 4 with a word already queued
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_data", data_out, 8'h77);
        send_frame(8'h99, 1'b1, 1'b0, 1'b1);
        step();
        chk("midreset_status", status_register, 8'h01);
        chk("midreset_data", data_out, 8'h00);
        repeat (100) step();
        chk("post_reset_idle", status_register, 8'h01);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        chk("after_reset_status", status_register, 8'h00);
        chk("after_reset_data", data_out, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
